// File: rtl/piano_pkg.sv
// Shared piano definitions: key count, the 50 MHz note period table
// (C4..C5, indexed by key number) and the note detector state encoding.
// The tone divider uses the same table, halved, for its half-period count.
package piano_pkg;

  localparam int unsigned NOTE_COUNT = 8;

  // One 32-bit period per key; element [k] is the period of key k.
  typedef logic [NOTE_COUNT-1:0][31:0] note_tab_t;

  localparam note_tab_t NOTE_PERIOD = {
    32'd95556,   // 7 C5
    32'd101239,  // 6 B4
    32'd113636,  // 5 A4
    32'd127551,  // 4 G4
    32'd143173,  // 3 F4
    32'd151686,  // 2 E4
    32'd170262,  // 1 D4
    32'd191113   // 0 C4
  };

  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} det_state_e;

endpackage

// File: rtl/note_detector_if.sv
// Bundle between a tone source / controller and the note detector.
//   en         enable from controller
//   tone_in    square-wave tone (asynchronous to clk)
//   chord      one-hot detected key, 0 when not locked
//   note_idx   index of the detected key, 0 when not locked
//   note_valid high while locked
//   period     last measured period in clk cycles
// master = controller/tone side, slave = detector.
interface note_detector_if #(
  parameter int unsigned CNT_W = 19
);
  logic             en;
  logic             tone_in;
  logic [7:0]       chord;
  logic [2:0]       note_idx;
  logic             note_valid;
  logic [CNT_W-1:0] period;

  modport master (
    output en, tone_in,
    input  chord, note_idx, note_valid, period
  );

  modport slave (
    input  en, tone_in,
    output chord, note_idx, note_valid, period
  );
endinterface

// File: rtl/edge_sync.sv
// Two-flop synchronizer plus edge flop for an asynchronous input.
//   clk  system clock
//   rst  asynchronous active-high reset, clears all three flops
//   din  asynchronous input
//   rise one-cycle pulse in the cycle where the synchronized input is 1
//        and was 0 the cycle before
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);
  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;
endmodule

// File: rtl/note_detector.sv
// Note detector: measures the clk-cycle period between rising edges of a
// square-wave tone and, after CONFIRM consecutive periods matching the same
// key within +/-TOL cycles, reports that key on the one-hot chord bus.
//   clk  system clock (50 MHz for the default table)
//   rst  asynchronous active-high reset
//   bus  slave side of note_detector_if (en, tone_in in; chord, note_idx,
//        note_valid, period out, all registered)
module note_detector
  import piano_pkg::*;
#(
  parameter int unsigned CNT_W   = 19,
  parameter int unsigned TOL     = 512,
  parameter int unsigned CONFIRM = 3,
  parameter int unsigned TIMEOUT = 400000,
  parameter note_tab_t   NOTES   = NOTE_PERIOD
) (
  input logic              clk,
  input logic              rst,
  note_detector_if.slave   bus
);

  if (TOL >= 2841) begin : g_bad_tol
    $error("TOL must stay below half the minimum note spacing");
  end
  if (CONFIRM < 1 || CONFIRM > 7) begin : g_bad_confirm
    $error("CONFIRM must be in 1..7");
  end
  if (TIMEOUT >= (1 << CNT_W)) begin : g_bad_timeout
    $error("CNT_W too narrow for TIMEOUT");
  end

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [2:0]       CONF_LOCK   = 3'(CONFIRM);

  logic rise;

  edge_sync u_edge_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.tone_in),
    .rise (rise)
  );

  det_state_e       state;
  logic [CNT_W-1:0] cnt;       // cycles since the last rise; equals P at the next rise
  logic [2:0]       cand;
  logic             cand_valid;
  logic [2:0]       conf;
  logic [7:0]       chord;
  logic [2:0]       note_idx;
  logic             note_valid;
  logic [CNT_W-1:0] period;

  // Window match of the current count against every key; tolerance is below
  // half the key spacing, so at most one key can hit.
  logic             hit;
  logic [2:0]       hit_k;
  logic [CNT_W:0]   p_ext;
  logic [CNT_W:0]   np;
  logic [CNT_W:0]   diff;

  always_comb begin
    hit   = 1'b0;
    hit_k = '0;
    p_ext = {1'b0, cnt};
    np    = '0;
    diff  = '0;
    for (int k = 0; k < int'(NOTE_COUNT); k++) begin
      np   = (CNT_W+1)'(NOTES[k]);
      diff = (p_ext >= np) ? (p_ext - np) : (np - p_ext);
      if (diff <= (CNT_W+1)'(TOL)) begin
        hit   = 1'b1;
        hit_k = 3'(k);
      end
    end
  end

  logic [2:0] conf_nx;

  always_comb begin
    conf_nx = 3'd1;
    if (cand_valid && (hit_k == cand)) conf_nx = conf + 3'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      cand       <= '0;
      cand_valid <= 1'b0;
      conf       <= '0;
      chord      <= '0;
      note_idx   <= '0;
      note_valid <= 1'b0;
      period     <= '0;
    end else if (!bus.en) begin
      state      <= IDLE;
      cnt        <= '0;
      cand       <= '0;
      cand_valid <= 1'b0;
      conf       <= '0;
      chord      <= '0;
      note_idx   <= '0;
      note_valid <= 1'b0;
      period     <= '0;
    end else begin
      if (rise) begin
        cnt <= CNT_W'(1);
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end

      // A rise takes priority over a timeout landing in the same cycle.
      if (rise) begin
        unique case (state)
          IDLE: state <= MEASURE;  // first rise only arms the counter
          MEASURE, LOCKED: begin
            period <= cnt;
            if (!hit) begin
              state      <= MEASURE;
              cand       <= '0;
              cand_valid <= 1'b0;
              conf       <= '0;
              chord      <= '0;
              note_idx   <= '0;
              note_valid <= 1'b0;
            end else if (state == LOCKED) begin
              if (hit_k != note_idx) begin
                state      <= MEASURE;
                cand       <= hit_k;
                cand_valid <= 1'b1;
                conf       <= 3'd1;
                chord      <= '0;
                note_idx   <= '0;
                note_valid <= 1'b0;
              end
            end else begin
              cand       <= hit_k;
              cand_valid <= 1'b1;
              conf       <= conf_nx;
              if (conf_nx == CONF_LOCK) begin
                state      <= LOCKED;
                chord      <= 8'b1 << hit_k;
                note_idx   <= hit_k;
                note_valid <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end else if (cnt == TIMEOUT_CNT) begin
        state      <= IDLE;
        cand       <= '0;
        cand_valid <= 1'b0;
        conf       <= '0;
        chord      <= '0;
        note_idx   <= '0;
        note_valid <= 1'b0;
        period     <= '0;
      end
    end
  end

  assign bus.chord      = chord;
  assign bus.note_idx   = note_idx;
  assign bus.note_valid = note_valid;
  assign bus.period     = period;

endmodule

// File: doc/note_detector.md
Name: note_detector

Overview:
- Decodes a single square-wave tone back into the one-hot 8-key chord bus, the inverse of the key-to-frequency divider path.
- Measures the clk-cycle period between rising edges of tone_in and matches it against the eight note periods.
- Asserts the matching key after CONFIRM consecutive agreeing periods.
- Used for loopback self-test of the tone generator and for an external tone input.

Parameters:
- CNT_W, 19, period counter width; must hold TIMEOUT.
- TOL, 512, match tolerance in clk cycles (±). Elaboration check: TOL < 2841, half the minimum note spacing.
- CONFIRM, 3, consecutive matching periods required to lock (1..7).
- TIMEOUT, 400000, clk cycles without a rising edge before the detector returns to idle.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  detector enable; low forces IDLE and clears outputs on the next clk edge.
- tone_in  in  1  asynchronous square-wave input.
- chord  out  8  one-hot detected key; 0 when not locked.
- note_idx  out  3  index of the detected key; 0 when not locked.
- note_valid  out  1  high while locked.
- period  out  CNT_W  last measured period in clk cycles, saturating.

Behaviour:
- Reset: while rst is high, all outputs, the counter, the candidate, the confirm count and the synchronizer flops are 0. Reset acts asynchronously, including mid-lock; state = IDLE.
- Synchronizer: tone_in passes through 2 flops plus an edge flop. A rise is detected in the cycle where sync=1 and prev=0. Pin-to-rise-detect latency is 2–3 clk.
- Period definition: P = number of clk cycles between two consecutive rise-detect cycles. The counter saturates at 2^CNT_W−1.
- Match rule:
  - P matches note k when |P − NOTE_PERIOD[k]| ≤ TOL.
  - At most one k can match.
  - Compare P as unsigned with CNT_W+1 bit intermediates; no wrap.
- Registered outputs: chord, note_idx, note_valid and period update on the clk edge after the rise-detect cycle (latency 1).
- State machine:
  - IDLE: waiting for the first rise. A rise clears the counter and goes to MEASURE with no measurement taken (it only arms).
  - MEASURE: on each rise, period is set to P.
    - If P matches k and k equals the candidate, conf is incremented; otherwise the candidate becomes k and conf = 1.
    - No match: candidate is invalid and conf = 0.
    - When conf reaches CONFIRM, go to LOCKED, chord = 1<<k, note_idx = k, note_valid = 1.
  - LOCKED: on each rise, period is updated.
    - A match to the same k holds the outputs.
    - A match to a different k, or no match, clears the outputs in that same update and goes to MEASURE. In that update the candidate becomes the new k with conf = 1, or is invalid on no match.
  - Any state: when the counter reaches TIMEOUT with no rise, go to IDLE, clear the outputs and confirm state, and set period = 0 on the next edge.
- Simultaneous rise and TIMEOUT in the same cycle: the rise wins.
- en low overrides everything except rst.
- Duty cycle of tone_in is irrelevant. Glitch filtering beyond the synchronizer is out of scope.

Decomposition:
- Shared package piano_pkg holds:
  - NOTE_COUNT = 8.
  - NOTE_PERIOD[0..7] at 50 MHz: 191113 (C4), 170262 (D4), 151686 (E4), 143173 (F4), 127551 (G4), 113636 (A4), 101239 (B4), 95556 (C5).
  - The detector state enum {IDLE, MEASURE, LOCKED}.
- The divider side consumes the same period table, halved.
- One sub-module: edge_sync. It contains the 2-flop synchronizer and rise detector, with async active-high rst, and outputs a rise pulse.

Test Plan:
1. Reset: assert rst with tone_in toggling → all outputs 0. Release with tone_in idle → outputs stay 0 for 500000 cycles.
2. A4 lock: square wave with period 113636, 4 rising edges → after the 4th edge plus latency: chord = 8'b0010_0000, note_idx = 5, note_valid = 1, period = 113636. After 3 edges: note_valid = 0.
3. Tolerance: period 113636+512 → locks on A4. Period 113636+513 → never valid, chord = 0, period = 114149.
4. Note change: lock on A4, then switch to period 191113. The first C4 period clears the outputs. After the 3rd C4 period: chord = 8'h01, note_idx = 0, note_valid = 1.
5. Timeout: lock on C5 (95556), then hold tone_in low. 400000 cycles after the last rise: outputs 0, period = 0. The next single rise only arms, with no output change.
6. Async reset mid-lock: pulse rst between clk edges while locked on G4 → outputs 0 immediately, without a clk edge. Relock needs 4 rising edges again.
